// File: rtl/mult_div_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mult_div_pkg;

  localparam int ITERATIONS = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MUL  = 2'd1;
  localparam state_t S_DIV  = 2'd2;
  localparam state_t S_DONE = 2'd3;

  localparam logic [5:0] LAST_ITER = 6'(ITERATIONS - 1);

endpackage

// File: rtl/mult_div_unit_addsub33.sv
// 33-bit adder/subtractor shared by multiply and divide iterations.
module addsub33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: shift-add multiply,
// restoring divide, sign fix-up on completion, MTHI/MTLO writes.
module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_in,
  input  logic [1:0]  op_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        hiWrite_in,
  input  logic        loWrite_in,
  input  logic [31:0] writeData_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        divZero_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  state_t      state;
  logic [5:0]  cnt;
  logic        fin;
  logic [1:0]  op_q;
  logic [31:0] a_raw;
  logic [31:0] opnd_b;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic        sgn_a;
  logic        sgn_b;
  logic        dz;

  logic        is_div;
  logic [32:0] add_a;
  logic [32:0] add_b;
  logic [32:0] add_y;
  logic        add_sub;

  logic        in_sa;
  logic        in_sb;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  logic [63:0] prod;
  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic        b_zero;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign is_div = op_q[1];

  assign in_sa = op_in[0] & a_in[31];
  assign in_sb = op_in[0] & b_in[31];
  assign mag_a = in_sa ? (32'd0 - a_in) : a_in;
  assign mag_b = in_sb ? (32'd0 - b_in) : b_in;

  // Divide shifts {rem, quo} left by one; multiply adds into the upper half.
  always_comb begin
    add_a   = {1'b0, acc_hi};
    add_b   = acc_lo[0] ? {1'b0, opnd_b} : 33'd0;
    add_sub = 1'b0;
    if (is_div) begin
      add_a   = {acc_hi, acc_lo[31]};
      add_b   = {1'b0, opnd_b};
      add_sub = 1'b1;
    end
  end

  addsub33 u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .y   (add_y)
  );

  assign prod   = {acc_hi, acc_lo};
  assign prod_s = (sgn_a ^ sgn_b) ? (64'd0 - prod) : prod;
  assign quo_s  = (sgn_a ^ sgn_b) ? (32'd0 - acc_lo) : acc_lo;
  assign rem_s  = sgn_a ? (32'd0 - acc_hi) : acc_hi;
  assign b_zero = (opnd_b == 32'd0);

  always_comb begin
    res_hi = prod_s[63:32];
    res_lo = prod_s[31:0];
    if (is_div) begin
      res_hi = b_zero ? a_raw : rem_s;
      res_lo = b_zero ? 32'hFFFF_FFFF : quo_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= 6'd0;
      fin    <= 1'b0;
      op_q   <= OP_MULTU;
      a_raw  <= 32'd0;
      opnd_b <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      dz     <= 1'b0;
      hi_out <= 32'd0;
      lo_out <= 32'd0;
    end else begin
      dz <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_in) begin
            state  <= op_in[1] ? S_DIV : S_MUL;
            cnt    <= 6'd0;
            fin    <= 1'b0;
            op_q   <= op_in;
            a_raw  <= a_in;
            opnd_b <= mag_b;
            acc_hi <= 32'd0;
            acc_lo <= mag_a;
            sgn_a  <= in_sa;
            sgn_b  <= in_sb;
          end else begin
            state <= S_IDLE;
            if (hiWrite_in) hi_out <= writeData_in;
            if (loWrite_in) lo_out <= writeData_in;
          end
        end
        S_MUL, S_DIV: begin
          if (fin) begin
            state  <= S_DONE;
            hi_out <= res_hi;
            lo_out <= res_lo;
            dz     <= is_div & b_zero;
          end else begin
            if (cnt == LAST_ITER) fin <= 1'b1;
            else cnt <= cnt + 6'd1;
            if (is_div) begin
              // Restore when the trial subtraction goes negative.
              if (!add_y[32]) begin
                acc_hi <= add_y[31:0];
                acc_lo <= {acc_lo[30:0], 1'b1};
              end else begin
                acc_hi <= add_a[31:0];
                acc_lo <= {acc_lo[30:0], 1'b0};
              end
            end else begin
              acc_hi <= add_y[32:1];
              acc_lo <= {add_y[0], acc_lo[31:1]};
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_out    = (state == S_MUL) || (state == S_DIV);
  assign done_out    = (state == S_DONE);
  assign divZero_out = done_out & dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus
// back-to-back, busy-ignore and mid-operation reset sequences.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_in;
  logic [1:0]  op_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        hiWrite_in;
  logic        loWrite_in;
  logic [31:0] writeData_in;
  logic        busy_out;
  logic        done_out;
  logic        divZero_out;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  mult_div_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start_in     (start_in),
    .op_in        (op_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .hiWrite_in   (hiWrite_in),
    .loWrite_in   (loWrite_in),
    .writeData_in (writeData_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .divZero_out  (divZero_out),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs [12];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    start_in = 1'b1;
    op_in    = op;
    a_in     = a;
    b_in     = b;
    tick();
    start_in = 1'b0;
  endtask

  // Counts edges after the accepting edge until done_out, bounded.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    do begin
      tick();
      n++;
    end while (!done_out && n < 45);
  endtask

  int lat;
  int pulses;

  initial begin
    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{OP_MULTU, 32'd5,        32'd6,        32'h00000000, 32'd30,       1'b0};
    vecs[6]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{OP_DIV,   32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{OP_MULT,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 1'b0};

    reset        = 1'b1;
    start_in     = 1'b1;
    op_in        = OP_MULTU;
    a_in         = 32'd5;
    b_in         = 32'd6;
    hiWrite_in   = 1'b0;
    loWrite_in   = 1'b0;
    writeData_in = 32'd0;
    tick();
    tick();
    check("reset_busy_over_start", {31'd0, busy_out}, 32'd0);
    start_in = 1'b0;
    reset    = 1'b0;
    tick();
    check("reset_busy", {31'd0, busy_out}, 32'd0);
    check("reset_done", {31'd0, done_out}, 32'd0);
    check("reset_dz", {31'd0, divZero_out}, 32'd0);
    check("reset_hi", hi_out, 32'd0);
    check("reset_lo", lo_out, 32'd0);

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), {31'd0, busy_out}, 32'd1);
      wait_done(0, lat);
      check($sformatf("v%0d_latency", i), lat, 32'd33);
      check($sformatf("v%0d_hi", i), hi_out, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo_out, vecs[i].lo);
      check($sformatf("v%0d_dz", i), {31'd0, divZero_out}, {31'd0, vecs[i].dz});
      tick();
      check($sformatf("v%0d_done_pulse", i), {31'd0, done_out}, 32'd0);
      check($sformatf("v%0d_dz_low", i), {31'd0, divZero_out}, 32'd0);
    end

    // Back-to-back: second start accepted in the DONE cycle.
    launch(OP_MULTU, 32'd5, 32'd6);
    wait_done(0, lat);
    check("b2b_first_lo", lo_out, 32'd30);
    launch(OP_DIVU, 32'd100, 32'd7);
    check("b2b_busy", {31'd0, busy_out}, 32'd1);
    wait_done(0, lat);
    check("b2b_latency", lat, 32'd33);
    check("b2b_hi", hi_out, 32'd2);
    check("b2b_lo", lo_out, 32'd14);
    tick();

    // Start wins over MTLO in IDLE; MTHI/MTLO and restart ignored while busy.
    loWrite_in   = 1'b1;
    writeData_in = 32'h1234;
    launch(OP_MULTU, 32'd5, 32'd6);
    loWrite_in = 1'b0;
    check("idle_prio_lo", lo_out, 32'd14);
    tick();
    tick();
    start_in     = 1'b1;
    op_in        = OP_DIVU;
    a_in         = 32'd99;
    b_in         = 32'd3;
    hiWrite_in   = 1'b1;
    loWrite_in   = 1'b1;
    writeData_in = 32'h1234;
    tick();
    start_in   = 1'b0;
    hiWrite_in = 1'b0;
    loWrite_in = 1'b0;
    check("busy_hold_hi", hi_out, 32'd2);
    check("busy_hold_lo", lo_out, 32'd14);
    wait_done(3, lat);
    check("ignore_latency", lat, 32'd33);
    check("ignore_hi", hi_out, 32'd0);
    check("ignore_lo", lo_out, 32'd30);
    tick();

    // MTHI in IDLE, then reset part-way through a divide.
    hiWrite_in   = 1'b1;
    writeData_in = 32'hABCD;
    tick();
    hiWrite_in = 1'b0;
    check("mthi_hi", hi_out, 32'hABCD);
    check("mthi_lo", lo_out, 32'd30);
    launch(OP_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", {31'd0, busy_out}, 32'd1);
    check("mid_hold_hi", hi_out, 32'hABCD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy_out}, 32'd0);
    check("abort_done", {31'd0, done_out}, 32'd0);
    check("abort_hi", hi_out, 32'd0);
    check("abort_lo", lo_out, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_out) pulses++;
    end
    check("abort_no_done", pulses, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous active-high reset, reset, both sampled on the rising edge of clk.
REQ-002 clk  in  1  system clock, shared with the PC register, register file and DMEM.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 start_in  in  1  request to begin an operation on a_in/b_in.
REQ-005 op_in  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a_in  in  32  rs operand (register file data1).
REQ-007 b_in  in  32  rt operand (register file data2).
REQ-008 hiWrite_in  in  1  MTHI strobe.
REQ-009 loWrite_in  in  1  MTLO strobe.
REQ-010 writeData_in  in  32  data for MTHI/MTLO.
REQ-011 busy_out  out  1  high while an operation is in progress; the top level stalls the PC on it.
REQ-012 done_out  out  1  one-cycle pulse when hi_out/lo_out hold a new result.
REQ-013 divZero_out  out  1  set with done_out when a divide had b_in == 0.
REQ-014 hi_out  out  32  HI register, read by MFHI.
REQ-015 lo_out  out  32  LO register, read by MFLO.

Function
REQ-016 The FSM SHALL have the states IDLE, MUL, DIV and DONE.
- IDLE -> MUL or DIV on start_in.
- MUL/DIV -> DONE after 32 iterations.
- DONE -> IDLE after one cycle.
REQ-017 start_in SHALL be accepted only in IDLE or DONE; a start from DONE goes directly to MUL or DIV.
REQ-018 start_in SHALL be ignored in MUL and DIV.
REQ-019 a_in, b_in and op_in SHALL be captured on the accepting edge; later changes have no effect.
REQ-020 busy_out SHALL be 1 exactly in MUL and DIV.
REQ-021 done_out SHALL be 1 exactly in DONE.
REQ-022 Latency: if start is accepted at edge k, the result SHALL appear in hi_out/lo_out, with done_out=1, in the cycle after edge k+33, for every op.
REQ-023 Multiply SHALL be iterative shift-add, one bit per cycle, on 32-bit magnitudes, giving a 64-bit product: HI = upper 32 bits, LO = lower 32 bits.
REQ-024 Divide SHALL be iterative restoring, one bit per cycle, with a 33-bit partial remainder: LO = quotient, HI = remainder.
REQ-025 Signed ops SHALL operate on magnitudes with sign correction at completion:
- product negated when operand signs differ;
- quotient negated when operand signs differ;
- remainder takes the sign of the dividend.
REQ-026 Divide by zero SHALL keep the normal latency and produce LO=32'hFFFFFFFF, HI=dividend (unmodified a_in), with divZero_out=1.
REQ-027 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL yield LO=32'h80000000, HI=0.
REQ-028 divZero_out SHALL be 0 whenever done_out is 0.
REQ-029 hiWrite_in/loWrite_in SHALL load writeData_in at the next edge only in IDLE or DONE, and are ignored while busy_out=1.
REQ-030 In IDLE, start_in SHALL take priority over hiWrite_in/loWrite_in in the same cycle; the write is dropped.
REQ-031 hi_out/lo_out SHALL hold their previous values throughout MUL/DIV and SHALL update only on entry to DONE or on an accepted MTHI/MTLO.

Reset
REQ-032 reset SHALL force IDLE, hi_out=0, lo_out=0, busy_out=0, done_out=0 and divZero_out=0 at the next edge.
REQ-033 reset SHALL take priority over start_in and MTHI/MTLO.
REQ-034 reset asserted mid-operation SHALL abort the operation and produce no done_out pulse.

Structure
REQ-035 The shared package mult_div_pkg SHALL hold the op encodings, the state enumeration and the constant ITERATIONS=32.
REQ-036 The shared 33-bit add/subtract for the multiply and divide iterations SHALL be one sub-module, addsub33.
REQ-037 The iteration counter SHALL be 6 bits and count 0..31; all other logic stays in mult_div_unit.

Verification
REQ-038 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> done_out 33 cycles after start, HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-039 MULT -3 x 7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
REQ-040 DIV -7 / 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF, divZero_out=0.
REQ-041 DIVU 100 / 0 -> LO=32'hFFFFFFFF, HI=32'h00000064, divZero_out=1 with done_out.
REQ-042 Start MULTU 5 x 6, then MTLO 32'h1234 and a second start during busy -> both ignored; result HI=0, LO=30 at the original latency.
REQ-043 MTHI 32'hABCD in IDLE, start DIV, reset on iteration 10 -> next cycle IDLE, HI=LO=0, no done_out pulse.
